keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset.
REQ-002 Parameter SCAN_DIV SHALL default to 50000 and sets the clock cycles per column slot; legal range is >=2.
REQ-003 Parameter DEBOUNCE_CNT SHALL default to 4 and sets the consecutive identical frames required; legal range is 1..15.
REQ-004 Port clk SHALL be input, 1 bit: the system clock.
REQ-005 Port rst SHALL be input, 1 bit: synchronous active-high reset.
REQ-006 Port row_n SHALL be input, 4 bits: keypad rows, active-low and asynchronous; bit i is row i.
REQ-007 Port col_n SHALL be output, 4 bits: keypad column drive, one-hot-low.
REQ-008 Port key_code SHALL be output, 4 bits: last accepted key, equal to row_idx*4 + col_idx.
REQ-009 Port key_valid SHALL be output, 1 bit: a one-cycle pulse on key acceptance.
REQ-010 Port key_held SHALL be output, 1 bit: high while the accepted key is debounced-pressed.

Function
REQ-011 row_n SHALL pass through a 2-flop synchronizer whose flops reset to 4'b1111.
REQ-012 A divider SHALL count 0..SCAN_DIV-1 and wrap; the cycle at terminal count is the "sample" cycle.
REQ-013 A 2-bit column index SHALL map to col_n as follows: 0->0111, 1->1011, 2->1101, 3->1110. The index advances after each sample, wrapping 3->0.
REQ-014 Each sample cycle SHALL examine the synchronized rows for the current column; a row bit at 0 means that key is pressed.
REQ-015 A frame SHALL be the four consecutive samples for columns 0..3 (4*SCAN_DIV cycles). The frame result is classified at the column-3 sample as NONE, SINGLE(code) or MULTI (two or more pressed keys).
REQ-016 The block SHALL also track per frame whether the current candidate key was pressed (cand_hit).
REQ-017 The FSM SHALL have four states: IDLE, DEBOUNCE, PRESSED and RELEASE. It evaluates only at frame end.
REQ-018 IDLE transitions:
- SINGLE(c) -> DEBOUNCE, with candidate=c and cnt=1.
- NONE or MULTI -> remain in IDLE.
REQ-019 DEBOUNCE transitions:
- SINGLE equal to the candidate: cnt increments.
- Any other result (NONE, MULTI, or a different SINGLE): -> IDLE.
REQ-020 Acceptance SHALL occur when cnt reaches DEBOUNCE_CNT, including the first frame when DEBOUNCE_CNT=1. On acceptance:
- the FSM moves to PRESSED;
- key_code is set to the candidate;
- key_valid pulses for exactly one cycle, the cycle after the frame-end sample.
REQ-021 PRESSED transitions:
- cand_hit=1 (even if the frame is MULTI): remain in PRESSED.
- cand_hit=0: -> RELEASE with cnt=1.
REQ-022 RELEASE transitions:
- cand_hit=0: cnt increments; when cnt reaches DEBOUNCE_CNT -> IDLE.
- cand_hit=1: -> PRESSED, with no new key_valid pulse.
REQ-023 key_held SHALL be 1 exactly in the PRESSED and RELEASE states.
REQ-024 key_code SHALL hold its value until the next acceptance.
REQ-025 The debounce counter SHALL saturate and never wrap.

Reset
REQ-026 While rst=1 at a clock edge, the next state SHALL be:
- col_n=4'b0111, column index 0, divider 0;
- key_code=0, key_valid=0, key_held=0;
- FSM in IDLE, cnt 0, candidate 0;
- synchronizer flops at 4'b1111.
REQ-027 Reset asserted mid-frame or in any FSM state SHALL discard the partial frame and emit no key_valid pulse.
REQ-028 The first frame after reset release SHALL start at column 0.

Verification
All benches use SCAN_DIV=4 and DEBOUNCE_CNT=2 (frame = 16 cycles). The keypad model drives row_n as a function of col_n.
REQ-029 Reset scenario: hold rst for 3 cycles -> col_n=0111, key_code=0, key_valid=0, key_held=0. After release, col_n steps 0111, 1011, 1101, 1110 every 4 cycles.
REQ-030 Clean press scenario: hold row1/col2 (row_n=1101 while col_n=1101) -> after the 2nd full frame, exactly one key_valid pulse; key_code=6; key_held=1 and stays 1 while the key is held.
REQ-031 Bounce scenario: press row3/col0 for one frame, then release -> no key_valid pulse; key_held stays 0; key_code unchanged.
REQ-032 Multi-key scenario: row0/col0 and row2/col3 pressed together from IDLE -> no key_valid. Then press row0/col0 alone for 2 frames -> a single pulse with key_code=0.
REQ-033 Release/glitch scenario: with key 6 accepted, release for 1 frame, repress, then release for 2 frames -> no second pulse; key_held=1 throughout the glitch; key_held=0 after the 2nd release frame.
REQ-034 Reset-in-PRESSED scenario: assert rst for 1 cycle while key_held=1 -> next cycle key_held=0, key_code=0, col_n=0111. With the key still held, re-acceptance occurs 2 frames later.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, row synchronizer, per-frame
// classification and press/release debounce with single-key acceptance.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0] DB = 4'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t state, state_nx;

    logic [3:0]    sync1, sync2;
    logic [DW-1:0] div;
    logic [1:0]    col;
    logic          sample, frame_end;

    logic [1:0] acc_cnt;
    logic [3:0] acc_code;
    logic       acc_hit;

    logic [3:0] hits;
    logic [2:0] s_pop;
    logic [1:0] s_row;
    logic [2:0] tot;
    logic [1:0] f_cnt;
    logic [3:0] f_code;
    logic       f_hit;

    logic [3:0] cnt, cnt_nx, cnt_inc;
    logic [3:0] cand, cand_nx;
    logic       accept;

    assign sample    = (div == DW'(SCAN_DIV - 1));
    assign frame_end = sample && (col == 2'd3);
    assign col_n     = ~(4'b1000 >> col);
    assign key_held  = (state == PRESSED) || (state == RELEASE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 4'b1111;
            sync2 <= 4'b1111;
            div   <= '0;
            col   <= 2'd0;
        end else begin
            sync1 <= row_n;
            sync2 <= sync1;
            if (sample) begin
                div <= '0;
                col <= col + 2'd1;
            end else begin
                div <= div + DW'(1);
            end
        end
    end

    // Per-sample decode; s_row is only meaningful when s_pop == 1
    always_comb begin
        hits  = ~sync2;
        s_pop = 3'd0;
        s_row = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (hits[i]) begin
                s_pop = s_pop + 3'd1;
                s_row = 2'(i);
            end
        end
        tot    = {1'b0, acc_cnt} + s_pop;
        f_cnt  = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        f_code = (s_pop == 3'd1) ? {s_row, col} : acc_code;
        f_hit  = acc_hit | ((col == cand[1:0]) && hits[cand[3:2]]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt  <= 2'd0;
            acc_code <= 4'd0;
            acc_hit  <= 1'b0;
        end else if (frame_end) begin
            acc_cnt  <= 2'd0;
            acc_code <= 4'd0;
            acc_hit  <= 1'b0;
        end else if (sample) begin
            acc_cnt  <= f_cnt;
            acc_code <= f_code;
            acc_hit  <= f_hit;
        end
    end

    assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cand_nx  = cand;
        accept   = 1'b0;
        if (frame_end) begin
            unique case (state)
                IDLE: begin
                    if (f_cnt == 2'd1) begin
                        state_nx = DEBOUNCE;
                        cand_nx  = f_code;
                        cnt_nx   = 4'd1;
                        accept   = (DB <= 4'd1);
                    end
                end
                DEBOUNCE: begin
                    if (f_cnt == 2'd1 && f_code == cand) begin
                        cnt_nx = cnt_inc;
                        accept = (cnt_inc >= DB);
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = 4'd0;
                    end
                end
                PRESSED: begin
                    if (!f_hit) begin
                        state_nx = RELEASE;
                        cnt_nx   = 4'd1;
                        if (DB <= 4'd1) begin
                            state_nx = IDLE;
                            cnt_nx   = 4'd0;
                        end
                    end
                end
                RELEASE: begin
                    if (f_hit) begin
                        state_nx = PRESSED;
                    end else if (cnt_inc >= DB) begin
                        state_nx = IDLE;
                        cnt_nx   = 4'd0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                default: state_nx = IDLE;
            endcase
            if (accept) state_nx = PRESSED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cand      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cand      <= cand_nx;
            key_valid <= accept;
            if (accept) key_code <= cand_nx;
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized scoreboard bench for keypad_scan_ctrl with a frame-level
// keypad and debounce reference model.
module tb_keypad_scan_ctrl;

    localparam int SD = 4;
    localparam int DB = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = 16'h0;

    int checks = 0;
    int failures = 0;

    logic [3:0] exp_q[$];

    // Reference model: abstract debounce phase per frame
    int         m_phase = 0;
    int         m_cnt = 0;
    logic [3:0] m_cand = 4'd0;
    logic [3:0] m_code = 4'd0;

    keypad_scan_ctrl #(
        .SCAN_DIV    (SD),
        .DEBOUNCE_CNT(DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key at (r,c) pulls row r low while column c is driven
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (col_n == ~(4'b1000 >> c)) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[r*4+c]) row_n[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_accept();
        m_phase = 2;
        m_code  = m_cand;
        exp_q.push_back(m_cand);
    endtask

    task automatic model_step(input logic [15:0] m);
        int n;
        int c;
        logic hit;
        n = $countones(m);
        c = 0;
        for (int i = 0; i < 16; i++) if (m[i]) c = i;
        hit = m[m_cand];
        case (m_phase)
            0: if (n == 1) begin
                m_phase = 1;
                m_cand  = 4'(c);
                m_cnt   = 1;
                if (m_cnt >= DB) model_accept();
            end
            1: if (n == 1 && 4'(c) == m_cand) begin
                m_cnt++;
                if (m_cnt >= DB) model_accept();
            end else begin
                m_phase = 0;
            end
            2: if (!hit) begin
                m_phase = 3;
                m_cnt   = 1;
                if (m_cnt >= DB) m_phase = 0;
            end
            default: if (hit) begin
                m_phase = 2;
            end else begin
                m_cnt++;
                if (m_cnt >= DB) m_phase = 0;
            end
        endcase
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_cand  = 4'd0;
        m_code  = 4'd0;
    endtask

    // Called at frame start (#1 after the edge that begins column 0)
    task automatic run_frame(input logic [15:0] m);
        model_step(m);
        keys = m;
        repeat (FRAME) @(posedge clk);
        #1;
        chk("key_held", 16'(key_held), 16'(m_phase >= 2));
        chk("key_code", 16'(key_code), 16'(m_code));
    endtask

    task automatic run_n(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) run_frame(m);
    endtask

    task automatic reset_mid(input logic [15:0] m, input int ncyc);
        keys = m;
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_held", 16'(key_held), 16'h0);
        chk("rst_code", 16'(key_code), 16'h0);
        chk("rst_col", 16'(col_n), 16'h7);
    endtask

    // Monitor: every key_valid pulse must match the next expected acceptance
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: code %0h with nothing expected at %0t",
                         key_code, $time);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    failures++;
                    $display("FAIL pulse_code: got %0h expected %0h at %0t",
                             key_code, e, $time);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col[4];
        exp_col = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_col", 16'(col_n), 16'h7);
        chk("reset_code", 16'(key_code), 16'h0);
        chk("reset_valid", 16'(key_valid), 16'h0);
        chk("reset_held", 16'(key_held), 16'h0);
        rst = 1'b0;

        model_step(16'h0);
        for (int i = 0; i < 4; i++) begin
            chk("col_step", 16'(col_n), 16'(exp_col[i]));
            repeat (SD) @(posedge clk);
            #1;
        end

        // Clean press of row1/col2 then release/glitch sequence
        run_n(16'h0040, 3);
        run_frame(16'h0000);
        run_frame(16'h0040);
        run_n(16'h0000, 2);

        // Bounce on row3/col0
        run_frame(16'h1000);
        run_frame(16'h0000);

        // Two keys together, then row0/col0 alone
        run_n(16'h0801, 2);
        run_n(16'h0001, 2);
        run_n(16'h0000, 2);

        // Reset while pressed, key still held
        run_n(16'h0040, 2);
        reset_mid(16'h0040, 5);
        run_n(16'h0040, 2);
        run_n(16'h0000, 2);

        for (int t = 0; t < 30; t++) begin
            int sel;
            int k;
            int k2;
            int n;
            logic [15:0] m;
            sel = $urandom_range(0, 4);
            k   = $urandom_range(0, 15);
            k2  = (k + $urandom_range(1, 15)) % 16;
            n   = $urandom_range(1, 4);
            m   = 16'h0;
            case (sel)
                0: m = 16'h0;
                1: m[k] = 1'b1;
                2: begin m[k] = 1'b1; m[k2] = 1'b1; end
                3: m = 16'($urandom);
                default: begin
                    m[k] = 1'b1;
                    run_n(m, 2);
                    m[k2] = 1'b1;
                end
            endcase
            run_n(m, n);
        end

        run_n(16'h0000, 3);
        chk("queue_drained", 16'(exp_q.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
